// File: rtl/johnson_counter_gen.sv
// Parametrised Johnson (twisted-ring) counter with up/down, enable,
// checked parallel load, registered binary phase and wrap pulse.
module johnson_counter_gen #(
   parameter int WIDTH = 4,
   parameter int PW    = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic [PW-1:0]    phase,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [PW-1:0]    LAST = PW'(2*WIDTH-1);
   localparam logic [WIDTH-1:0] ONES = '1;

   logic [WIDTH-1:0] out_q, out_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;

   logic             ld_ok;
   logic [PW-1:0]    ld_ph;
   logic [WIDTH-1:0] up_out, dn_out;
   logic [PW-1:0]    up_ph, dn_ph;

   // classify the load value and find its phase index
   always_comb begin
      ld_ok = 1'b0;
      ld_ph = '0;
      for (int k = 0; k <= WIDTH; k++) begin
         if (load_val == (ONES >> (WIDTH - k))) begin
            ld_ok = 1'b1;
            ld_ph = PW'(k);
         end
      end
      for (int j = 1; j < WIDTH; j++) begin
         if (load_val == (ONES << (WIDTH - j))) begin
            ld_ok = 1'b1;
            ld_ph = PW'(2*WIDTH - j);
         end
      end
   end

   // one step in each direction, phase tracked alongside the ring
   always_comb begin
      up_out = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
      dn_out = {~out_q[0], out_q[WIDTH-1:1]};
      up_ph  = (phase_q == LAST) ? '0 : phase_q + PW'(1);
      dn_ph  = (phase_q == '0) ? LAST : phase_q - PW'(1);
   end

   // next state: load beats enable, enable beats hold
   always_comb begin
      out_d   = out_q;
      phase_d = phase_q;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      if (load) begin
         out_d   = ld_ok ? load_val : '0;
         phase_d = ld_ok ? ld_ph : '0;
         err_d   = ~ld_ok;
      end else if (en) begin
         out_d   = dir ? dn_out : up_out;
         phase_d = dir ? dn_ph : up_ph;
         wrap_d  = dir ? (dn_out == '0) : (up_out == '0);
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         phase_q <= '0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         out_q   <= out_d;
         phase_q <= phase_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign out      = out_q;
   assign phase    = phase_q;
   assign wrap     = wrap_q;
   assign load_err = err_q;

endmodule

// File: tb/tb_johnson_counter_gen.sv
// Bench for johnson_counter_gen: WIDTH 4, 5 and 2 instances driven in
// parallel and checked against a phase-based reference model.
module tb_johnson_counter_gen;

   logic        clk = 1'b0;
   logic        rst, en, dir, load;
   logic [31:0] lv;

   logic [3:0] o4; logic [2:0] p4; logic w4, e4;
   logic [4:0] o5; logic [3:0] p5; logic w5, e5;
   logic [1:0] o2; logic [1:0] p2; logic w2, e2;

   always #5 clk = ~clk;

   johnson_counter_gen #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
      .load_val(lv[3:0]), .out(o4), .phase(p4), .wrap(w4), .load_err(e4));
   johnson_counter_gen #(.WIDTH(5)) u5 (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
      .load_val(lv[4:0]), .out(o5), .phase(p5), .wrap(w5), .load_err(e5));
   johnson_counter_gen #(.WIDTH(2)) u2 (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
      .load_val(lv[1:0]), .out(o2), .phase(p2), .wrap(w2), .load_err(e2));

   int errors = 0;
   int checks = 0;

   int wd[3] = '{4, 5, 2};
   int ph[3];
   bit wr[3];
   bit er[3];

   // Johnson code of phase p: p ones at LSB for p<=W, else 2W-p ones at MSB
   function automatic logic [31:0] out_of(int p, int w);
      int j;
      if (p <= w) return (32'd1 << p) - 32'd1;
      j = 2*w - p;
      return ((32'd1 << j) - 32'd1) << (w - j);
   endfunction

   function automatic logic [31:0] aout(int i);
      case (i)
         0: return 32'(o4);
         1: return 32'(o5);
         default: return 32'(o2);
      endcase
   endfunction

   function automatic logic [31:0] aph(int i);
      case (i)
         0: return 32'(p4);
         1: return 32'(p5);
         default: return 32'(p2);
      endcase
   endfunction

   function automatic logic awr(int i);
      case (i)
         0: return w4;
         1: return w5;
         default: return w2;
      endcase
   endfunction

   function automatic logic aer(int i);
      case (i)
         0: return e4;
         1: return e5;
         default: return e2;
      endcase
   endfunction

   task automatic check(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", n, a, e);
      end
   endtask

   task automatic model_update();
      for (int i = 0; i < 3; i++) begin
         int w, n, found;
         logic [31:0] v;
         w = wd[i];
         n = 2*w;
         v = lv & ((32'd1 << w) - 32'd1);
         if (rst) begin
            ph[i] = 0; wr[i] = 0; er[i] = 0;
         end else if (load) begin
            found = -1;
            for (int p = 0; p < n; p++)
               if (out_of(p, w) == v) found = p;
            ph[i] = (found < 0) ? 0 : found;
            er[i] = (found < 0);
            wr[i] = 0;
         end else if (en) begin
            ph[i] = dir ? (ph[i] + n - 1) % n : (ph[i] + 1) % n;
            wr[i] = (ph[i] == 0);
            er[i] = 0;
         end else begin
            wr[i] = 0; er[i] = 0;
         end
      end
   endtask

   task automatic model_check();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("w%0d_out", wd[i]), aout(i), out_of(ph[i], wd[i]));
         check($sformatf("w%0d_phase", wd[i]), aph(i), 32'(ph[i]));
         check($sformatf("w%0d_wrap", wd[i]), 32'(awr(i)), 32'(wr[i]));
         check($sformatf("w%0d_err", wd[i]), 32'(aer(i)), 32'(er[i]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      model_check();
   endtask

   task automatic drive(bit r, bit e, bit d, bit l, logic [31:0] v);
      rst = r; en = e; dir = d; load = l; lv = v;
   endtask

   typedef struct {
      bit       r, e, d, l;
      logic [3:0] v;
      logic [3:0] eo;
      int       eph;
      bit       ew, ee;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit r, bit e, bit d, bit l, logic [3:0] v,
                               logic [3:0] eo, int eph, bit ew, bit ee);
      vec_t t;
      t = '{r, e, d, l, v, eo, eph, ew, ee};
      tbl.push_back(t);
   endfunction

   initial begin
      int last[3];
      int nw[3];
      drive(1, 0, 0, 0, 0);

      // reset then up count
      add(1,0,0,0,4'h0, 4'b0000,0,0,0);
      add(1,0,0,0,4'h0, 4'b0000,0,0,0);
      add(0,1,0,0,4'h0, 4'b0001,1,0,0);
      add(0,1,0,0,4'h0, 4'b0011,2,0,0);
      add(0,1,0,0,4'h0, 4'b0111,3,0,0);
      add(0,1,0,0,4'h0, 4'b1111,4,0,0);
      add(0,1,0,0,4'h0, 4'b1110,5,0,0);
      add(0,1,0,0,4'h0, 4'b1100,6,0,0);
      add(0,1,0,0,4'h0, 4'b1000,7,0,0);
      add(0,1,0,0,4'h0, 4'b0000,0,1,0);
      // down count and reversal
      add(0,1,1,0,4'h0, 4'b1000,7,0,0);
      add(0,1,1,0,4'h0, 4'b1100,6,0,0);
      add(0,1,1,0,4'h0, 4'b1110,5,0,0);
      add(0,1,0,0,4'h0, 4'b1100,6,0,0);
      // hold at 0111
      add(0,0,0,1,4'h7, 4'b0111,3,0,0);
      for (int k = 0; k < 5; k++)
         add(0,0,0,0,4'h0, 4'b0111,3,0,0);
      // load wins over enable
      add(0,1,0,1,4'he, 4'b1110,5,0,0);
      // illegal load then count
      add(0,0,0,1,4'h5, 4'b0000,0,0,1);
      add(0,1,0,0,4'h0, 4'b0001,1,0,0);
      // down wrap from 0001
      add(0,1,1,0,4'h0, 4'b0000,0,1,0);
      add(0,1,1,0,4'h0, 4'b1000,7,0,0);
      // reset beats load at phase 6
      add(0,0,0,1,4'hc, 4'b1100,6,0,0);
      add(1,1,0,1,4'h5, 4'b0000,0,0,0);

      #2;
      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].l, 32'(tbl[i].v));
         step();
         check($sformatf("t%0d_out", i), 32'(o4), 32'(tbl[i].eo));
         check($sformatf("t%0d_phase", i), 32'(p4), 32'(tbl[i].eph));
         check($sformatf("t%0d_wrap", i), 32'(w4), 32'(tbl[i].ew));
         check($sformatf("t%0d_err", i), 32'(e4), 32'(tbl[i].ee));
      end

      // wrap period in both directions for every width
      for (int d = 0; d < 2; d++) begin
         drive(1, 0, 0, 0, 0);
         step();
         for (int i = 0; i < 3; i++) begin
            last[i] = -1;
            nw[i] = 0;
         end
         drive(0, 1, d[0], 0, 0);
         for (int c = 1; c <= 40; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
               if (awr(i) === 1'b1) begin
                  if (last[i] >= 0)
                     check($sformatf("w%0d_period", wd[i]),
                           32'(c - last[i]), 32'(2*wd[i]));
                  last[i] = c;
                  nw[i]++;
               end
            end
         end
         for (int i = 0; i < 3; i++)
            check($sformatf("w%0d_nwraps", wd[i]),
                  32'(nw[i]), 32'(40 / (2*wd[i])));
      end

      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         logic [31:0] v;
         v = $urandom;
         if ($urandom_range(0, 1) == 0)
            v = out_of($urandom_range(0, 9), 5) | 32'h0;
         drive($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
               1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, v);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
